// File: rtl/ppu_pkg.sv
// ppu_pkg
//   Shared definitions for the PPU CPU-side register window.
//   - ppu_reg_e  : register offsets ($2000-$2007 -> 0..7)
//   - STAT_*     : bit positions inside PPUSTATUS
//   - CTRL_*     : bit positions inside PPUCTRL used by the register block
//   - VINC_*     : v-address step sizes selected by PPUCTRL[2]
//   - vaddr_step : v-address increment, wrapping modulo 2^15
package ppu_pkg;

  typedef enum logic [2:0] {
    PPU_CTRL    = 3'd0,
    PPU_MASK    = 3'd1,
    PPU_STATUS  = 3'd2,
    PPU_OAMADDR = 3'd3,
    PPU_OAMDATA = 3'd4,
    PPU_SCROLL  = 3'd5,
    PPU_ADDR    = 3'd6,
    PPU_DATA    = 3'd7
  } ppu_reg_e;

  localparam int STAT_VBLANK = 7;
  localparam int STAT_SPR0   = 6;
  localparam int STAT_OVF    = 5;

  localparam int CTRL_VINC   = 2;
  localparam int CTRL_NMI    = 7;

  localparam logic [14:0] VINC_1  = 15'd1;
  localparam logic [14:0] VINC_32 = 15'd32;

  // Natural 15-bit overflow gives the mod-2^15 wrap.
  function automatic logic [14:0] vaddr_step(input logic [14:0] v, input logic inc32);
    return v + (inc32 ? VINC_32 : VINC_1);
  endfunction

endpackage

// File: rtl/ppu_cpu_regs_addr_latch.sv
// ppu_addr_latch
//   Shared $2005/$2006 write toggle with the t (temporary) and v (current)
//   VRAM addresses and fine X scroll.
//   Ports: wr_ctrl/wr_scroll/wr_addr  decoded CPU writes to $2000/$2005/$2006
//          data_acc                   any $2007 access (advances v)
//          status_rd                  $2002 read (clears the toggle)
//          inc32                      PPUCTRL[2], selects +32 step
//          d                          CPU write data
//          v_ext_we/v_ext             renderer overwrite of v, wins over CPU
//          t_addr/v_addr/fine_x       registered state
module ppu_addr_latch
  import ppu_pkg::*;
#(
  parameter int VADDR_W = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_ctrl,
  input  logic               wr_scroll,
  input  logic               wr_addr,
  input  logic               data_acc,
  input  logic               status_rd,
  input  logic               inc32,
  input  logic [7:0]         d,
  input  logic               v_ext_we,
  input  logic [VADDR_W-1:0] v_ext,
  output logic [VADDR_W-1:0] t_addr,
  output logic [VADDR_W-1:0] v_addr,
  output logic [2:0]         fine_x
);

  logic [VADDR_W-1:0] t_r, v_r, t_nx_s, v_cpu_s, v_nx_s;
  logic [2:0]         fx_r, fx_nx_s;
  logic               w_r, w_nx_s;

  // Next-state for t, fine_x, toggle and the CPU's view of v.
  always_comb begin
    t_nx_s  = t_r;
    v_cpu_s = v_r;
    fx_nx_s = fx_r;
    w_nx_s  = w_r;
    if (wr_ctrl) begin
      t_nx_s[11:10] = d[1:0];
    end else if (wr_scroll) begin
      if (!w_r) begin
        t_nx_s[4:0] = d[7:3];
        fx_nx_s     = d[2:0];
        w_nx_s      = 1'b1;
      end else begin
        t_nx_s[14:12] = d[2:0];
        t_nx_s[9:5]   = d[7:3];
        w_nx_s        = 1'b0;
      end
    end else if (wr_addr) begin
      if (!w_r) begin
        t_nx_s[13:8] = d[5:0];
        t_nx_s[14]   = 1'b0;
        w_nx_s       = 1'b1;
      end else begin
        // v takes the fully assembled t on the same edge
        t_nx_s[7:0] = d;
        v_cpu_s     = t_nx_s;
        w_nx_s      = 1'b0;
      end
    end else if (data_acc) begin
      v_cpu_s = vaddr_step(v_r, inc32);
    end else if (status_rd) begin
      w_nx_s = 1'b0;
    end else begin
      w_nx_s = w_r;
    end
    v_nx_s = v_ext_we ? v_ext : v_cpu_s;
  end

  // Address latch state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_r  <= 15'd0;
      v_r  <= 15'd0;
      fx_r <= 3'd0;
      w_r  <= 1'b0;
    end else begin
      t_r  <= t_nx_s;
      v_r  <= v_nx_s;
      fx_r <= fx_nx_s;
      w_r  <= w_nx_s;
    end
  end

  assign t_addr = t_r;
  assign v_addr = v_r;
  assign fine_x = fx_r;

endmodule

// File: rtl/ppu_cpu_regs.sv
// ppu_cpu_regs
//   CPU-bus responder for the PPU register window ($2000-$2007, mirrored).
//   Bus side : acc/rw/addr/wdata in, registered rdata out, nmi level out.
//   Renderer : vblank_set/vblank_clr/spr0_hit/spr_ovf flag pulses, v_ext_we/v_ext.
//   Outputs  : ctrl_q, mask_q, t_addr, v_addr, fine_x.
//   OAM      : oam_addr, oam_we/oam_wdata strobe, oam_rdata combinational in.
//   VRAM     : vram_addr/vram_we/vram_re/vram_wdata strobes, vram_rdata
//              valid the clk after vram_re.
module ppu_cpu_regs
  import ppu_pkg::*;
#(
  parameter int VADDR_W = 15,
  parameter int MADDR_W = 14
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               acc,
  input  logic               rw,
  input  logic [2:0]         addr,
  input  logic [7:0]         wdata,
  output logic [7:0]         rdata,
  output logic               nmi,
  input  logic               vblank_set,
  input  logic               vblank_clr,
  input  logic               spr0_hit,
  input  logic               spr_ovf,
  output logic [7:0]         ctrl_q,
  output logic [7:0]         mask_q,
  output logic [VADDR_W-1:0] t_addr,
  output logic [VADDR_W-1:0] v_addr,
  output logic [2:0]         fine_x,
  input  logic               v_ext_we,
  input  logic [VADDR_W-1:0] v_ext,
  output logic [7:0]         oam_addr,
  output logic               oam_we,
  output logic [7:0]         oam_wdata,
  input  logic [7:0]         oam_rdata,
  output logic [MADDR_W-1:0] vram_addr,
  output logic               vram_we,
  output logic               vram_re,
  output logic [7:0]         vram_wdata,
  input  logic [7:0]         vram_rdata
);

  ppu_reg_e           reg_sel_s;
  logic               wr_s, rd_s, status_rd_s, data_acc_s;
  logic               vblank_r, spr0_r, ovf_r, nmi_r;
  logic               vblank_nx_s, spr0_nx_s, ovf_nx_s;
  logic [7:0]         ctrl_r, ctrl_nx_s, mask_r, io_latch_r, rd_val_s;
  logic [7:0]         oam_addr_r, oam_wdata_r, rd_buf_r, rdata_r, vram_wdata_r;
  logic               oam_we_r, vram_we_r, vram_re_r, rd_pend_r;
  logic [MADDR_W-1:0] vram_addr_r;

  assign reg_sel_s   = ppu_reg_e'(addr);
  assign wr_s        = acc & ~rw;
  assign rd_s        = acc & rw;
  assign status_rd_s = rd_s & (reg_sel_s == PPU_STATUS);
  assign data_acc_s  = acc & (reg_sel_s == PPU_DATA);

  ppu_addr_latch #(.VADDR_W(VADDR_W)) u_addr_latch (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_ctrl   (wr_s & (reg_sel_s == PPU_CTRL)),
    .wr_scroll (wr_s & (reg_sel_s == PPU_SCROLL)),
    .wr_addr   (wr_s & (reg_sel_s == PPU_ADDR)),
    .data_acc  (data_acc_s),
    .status_rd (status_rd_s),
    .inc32     (ctrl_r[CTRL_VINC]),
    .d         (wdata),
    .v_ext_we  (v_ext_we),
    .v_ext     (v_ext),
    .t_addr    (t_addr),
    .v_addr    (v_addr),
    .fine_x    (fine_x)
  );

  // Read data selection; write-only registers echo the last written byte.
  always_comb begin
    case (reg_sel_s)
      PPU_STATUS:  rd_val_s = {vblank_r, spr0_r, ovf_r, io_latch_r[4:0]};
      PPU_OAMDATA: rd_val_s = oam_rdata;
      PPU_DATA:    rd_val_s = rd_buf_r;
      default:     rd_val_s = io_latch_r;
    endcase
  end

  // Flag and PPUCTRL next-state; a $2002 read or a clear beats a set.
  always_comb begin
    vblank_nx_s = vblank_r;
    spr0_nx_s   = spr0_r;
    ovf_nx_s    = ovf_r;
    if (vblank_clr) begin
      vblank_nx_s = 1'b0;
      spr0_nx_s   = 1'b0;
      ovf_nx_s    = 1'b0;
    end else begin
      if (status_rd_s) begin
        vblank_nx_s = 1'b0;
      end else if (vblank_set) begin
        vblank_nx_s = 1'b1;
      end else begin
        vblank_nx_s = vblank_r;
      end
      spr0_nx_s = spr0_r | spr0_hit;
      ovf_nx_s  = ovf_r | spr_ovf;
    end
    if (wr_s && (reg_sel_s == PPU_CTRL)) begin
      ctrl_nx_s = wdata;
    end else begin
      ctrl_nx_s = ctrl_r;
    end
  end

  // Control/mask/io latch, status flags and the registered nmi level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_r     <= 8'h00;
      mask_r     <= 8'h00;
      io_latch_r <= 8'h00;
      vblank_r   <= 1'b0;
      spr0_r     <= 1'b0;
      ovf_r      <= 1'b0;
      nmi_r      <= 1'b0;
    end else begin
      ctrl_r   <= ctrl_nx_s;
      vblank_r <= vblank_nx_s;
      spr0_r   <= spr0_nx_s;
      ovf_r    <= ovf_nx_s;
      nmi_r    <= vblank_nx_s & ctrl_nx_s[CTRL_NMI];
      if (wr_s) begin
        io_latch_r <= wdata;
      end else begin
        io_latch_r <= io_latch_r;
      end
      if (wr_s && (reg_sel_s == PPU_MASK)) begin
        mask_r <= wdata;
      end else begin
        mask_r <= mask_r;
      end
    end
  end

  // OAM port: the address advances the clk after the strobe so that the
  // strobe is presented together with the address it writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oam_addr_r  <= 8'h00;
      oam_we_r    <= 1'b0;
      oam_wdata_r <= 8'h00;
    end else begin
      oam_we_r <= wr_s & (reg_sel_s == PPU_OAMDATA);
      if (wr_s && (reg_sel_s == PPU_OAMDATA)) begin
        oam_wdata_r <= wdata;
      end else begin
        oam_wdata_r <= oam_wdata_r;
      end
      if (wr_s && (reg_sel_s == PPU_OAMADDR)) begin
        oam_addr_r <= wdata;
      end else if (oam_we_r) begin
        oam_addr_r <= oam_addr_r + 8'd1;
      end else begin
        oam_addr_r <= oam_addr_r;
      end
    end
  end

  // VRAM strobes, $2007 read buffer fill and registered read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vram_addr_r  <= '0;
      vram_we_r    <= 1'b0;
      vram_re_r    <= 1'b0;
      vram_wdata_r <= 8'h00;
      rd_pend_r    <= 1'b0;
      rd_buf_r     <= 8'h00;
      rdata_r      <= 8'h00;
    end else begin
      vram_we_r <= data_acc_s & ~rw;
      vram_re_r <= data_acc_s & rw;
      rd_pend_r <= vram_re_r;
      if (data_acc_s) begin
        vram_addr_r <= v_addr[MADDR_W-1:0];
      end else begin
        vram_addr_r <= vram_addr_r;
      end
      if (data_acc_s && !rw) begin
        vram_wdata_r <= wdata;
      end else begin
        vram_wdata_r <= vram_wdata_r;
      end
      // memory answers one clk after the read strobe
      if (rd_pend_r) begin
        rd_buf_r <= vram_rdata;
      end else begin
        rd_buf_r <= rd_buf_r;
      end
      if (rd_s) begin
        rdata_r <= rd_val_s;
      end else begin
        rdata_r <= rdata_r;
      end
    end
  end

  assign rdata      = rdata_r;
  assign nmi        = nmi_r;
  assign ctrl_q     = ctrl_r;
  assign mask_q     = mask_r;
  assign oam_addr   = oam_addr_r;
  assign oam_we     = oam_we_r;
  assign oam_wdata  = oam_wdata_r;
  assign vram_addr  = vram_addr_r;
  assign vram_we    = vram_we_r;
  assign vram_re    = vram_re_r;
  assign vram_wdata = vram_wdata_r;

endmodule

// File: tb/tb_ppu_cpu_regs.sv
// Self-checking bench for ppu_cpu_regs: directed scenarios plus a randomized
// sequence compared against a behavioural model of the register window.
module tb_ppu_cpu_regs;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        acc = 1'b0, rw = 1'b0;
  logic [2:0]  addr = 3'd0;
  logic [7:0]  wdata = 8'h00;
  logic [7:0]  rdata;
  logic        nmi;
  logic        vblank_set = 1'b0, vblank_clr = 1'b0, spr0_hit = 1'b0, spr_ovf = 1'b0;
  logic [7:0]  ctrl_q, mask_q;
  logic [14:0] t_addr, v_addr;
  logic [2:0]  fine_x;
  logic        v_ext_we = 1'b0;
  logic [14:0] v_ext = 15'd0;
  logic [7:0]  oam_addr, oam_wdata, oam_rdata;
  logic        oam_we;
  logic [13:0] vram_addr;
  logic        vram_we, vram_re;
  logic [7:0]  vram_wdata;
  logic [7:0]  vram_rdata;

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  ppu_cpu_regs dut (
    .clk(clk), .rst_n(rst_n), .acc(acc), .rw(rw), .addr(addr), .wdata(wdata),
    .rdata(rdata), .nmi(nmi), .vblank_set(vblank_set), .vblank_clr(vblank_clr),
    .spr0_hit(spr0_hit), .spr_ovf(spr_ovf), .ctrl_q(ctrl_q), .mask_q(mask_q),
    .t_addr(t_addr), .v_addr(v_addr), .fine_x(fine_x), .v_ext_we(v_ext_we),
    .v_ext(v_ext), .oam_addr(oam_addr), .oam_we(oam_we), .oam_wdata(oam_wdata),
    .oam_rdata(oam_rdata), .vram_addr(vram_addr), .vram_we(vram_we),
    .vram_re(vram_re), .vram_wdata(vram_wdata), .vram_rdata(vram_rdata)
  );

  // ---------------- environment memories ----------------
  function automatic logic [7:0] vinit(input int a);
    return 8'((a * 37) + (a >> 8)) ^ 8'h5A;
  endfunction

  logic [7:0] vmem [0:16383];

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16384; i++) vmem[i] <= vinit(i);
      vram_rdata <= 8'h00;
    end else begin
      if (vram_we) vmem[vram_addr] <= vram_wdata;
      if (vram_re) vram_rdata <= vmem[vram_addr];
    end
  end

  assign oam_rdata = oam_addr ^ 8'h5A;

  // ---------------- reference model ----------------
  int m_t, m_v, m_w, m_fx, m_ctrl, m_mask, m_vbl, m_spr0, m_ovf, m_io, m_oam, m_rdbuf;
  logic [7:0] m_rdata;
  logic [7:0] m_vram [0:16383];

  task automatic mdl_reset();
    m_t = 0; m_v = 0; m_w = 0; m_fx = 0; m_ctrl = 0; m_mask = 0;
    m_vbl = 0; m_spr0 = 0; m_ovf = 0; m_io = 0; m_oam = 0; m_rdbuf = 0;
    m_rdata = 8'h00;
    for (int i = 0; i < 16384; i++) m_vram[i] = vinit(i);
  endtask

  task automatic mdl_step(input bit acc_i, input bit rw_i, input int a, input int d,
                          input int side, input int vx);
    int step;
    bit st_rd;
    step  = ((m_ctrl & 4) != 0) ? 32 : 1;
    st_rd = acc_i && rw_i && (a == 2);
    if (acc_i && !rw_i) begin
      m_io = d;
      case (a)
        0: begin m_ctrl = d; m_t = (m_t & ~(3 << 10)) | ((d & 3) << 10); end
        1: m_mask = d;
        3: m_oam = d;
        4: m_oam = (m_oam + 1) % 256;
        5: if (m_w == 0) begin m_t = (m_t & ~'h1F) | (d >> 3); m_fx = d & 7; m_w = 1; end
           else begin m_t = (m_t & ~'h73E0) | ((d & 7) << 12) | ((d >> 3) << 5); m_w = 0; end
        6: if (m_w == 0) begin m_t = (m_t & 'hFF) | ((d & 'h3F) << 8); m_w = 1; end
           else begin m_t = (m_t & 'h7F00) | d; m_v = m_t; m_w = 0; end
        7: begin m_vram[m_v % 16384] = 8'(d); m_v = (m_v + step) % 32768; end
        default: ;
      endcase
    end else if (acc_i) begin
      case (a)
        2: begin m_rdata = 8'((m_vbl << 7) | (m_spr0 << 6) | (m_ovf << 5) | (m_io & 'h1F)); m_w = 0; end
        4: m_rdata = 8'(m_oam ^ 'h5A);
        7: begin m_rdata = 8'(m_rdbuf); m_rdbuf = m_vram[m_v % 16384]; m_v = (m_v + step) % 32768; end
        default: m_rdata = 8'(m_io);
      endcase
    end
    if ((side & 8) != 0) begin
      m_vbl = 0; m_spr0 = 0; m_ovf = 0;
    end else begin
      if (st_rd) m_vbl = 0;
      else if ((side & 1) != 0) m_vbl = 1;
      if ((side & 2) != 0) m_spr0 = 1;
      if ((side & 4) != 0) m_ovf = 1;
    end
    if ((side & 16) != 0) m_v = vx % 32768;
  endtask

  function automatic logic m_nmi();
    return (m_vbl != 0) && ((m_ctrl & 'h80) != 0);
  endfunction

  // ---------------- driver ----------------
  logic [7:0]  s_rdata, s_vwd, s_owd, s_oaddr;
  logic [13:0] s_vaddr;
  logic        s_nmi, s_vwe, s_vre, s_owe, s_strobe2;

  // One bus/renderer clk, sampled at the following negedge, then idle.
  task automatic drive(input bit acc_i, input bit rw_i, input int a, input int d,
                       input int side, input int vx);
    @(negedge clk);
    acc = acc_i; rw = rw_i; addr = 3'(a); wdata = 8'(d);
    vblank_set = side[0]; spr0_hit = side[1]; spr_ovf = side[2];
    vblank_clr = side[3]; v_ext_we = side[4]; v_ext = 15'(vx);
    @(negedge clk);
    s_rdata = rdata; s_nmi = nmi; s_vwe = vram_we; s_vre = vram_re;
    s_vaddr = vram_addr; s_vwd = vram_wdata; s_owe = oam_we; s_oaddr = oam_addr; s_owd = oam_wdata;
    acc = 1'b0; rw = 1'b0; vblank_set = 1'b0; spr0_hit = 1'b0; spr_ovf = 1'b0;
    vblank_clr = 1'b0; v_ext_we = 1'b0;
    mdl_step(acc_i, rw_i, a, d, side, vx);
    @(negedge clk);
    s_strobe2 = vram_we | vram_re | oam_we;
    repeat (2) @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    mdl_reset();
    repeat (3) @(negedge clk);
    n_tot++; if ({rdata, nmi, vram_we, vram_re, oam_we} !== 12'h000) $display("FAIL reset_outs: got %h exp 000", {rdata, nmi, vram_we, vram_re, oam_we}); else n_pass++;
    n_tot++; if ({t_addr, v_addr} !== 30'd0) $display("FAIL reset_tv: got %h/%h exp 0/0", t_addr, v_addr); else n_pass++;
    rst_n = 1'b1;
    drive(1, 1, 2, 0, 0, 0);
    n_tot++; if (s_rdata !== 8'h00) $display("FAIL reset_status: got %h exp 00", s_rdata); else n_pass++;
    n_tot++; if ({s_nmi, s_vwe, s_vre, s_owe} !== 4'b0000) $display("FAIL reset_strobes: got %b exp 0000", {s_nmi, s_vwe, s_vre, s_owe}); else n_pass++;
  endtask

  task automatic test_vram_write();
    drive(1, 0, 6, 'h21, 0, 0);
    drive(1, 0, 6, 'h08, 0, 0);
    n_tot++; if (t_addr !== 15'h2108 || v_addr !== 15'h2108) $display("FAIL addr_2006: got t=%h v=%h exp 2108", t_addr, v_addr); else n_pass++;
    drive(1, 0, 7, 'hAA, 0, 0);
    n_tot++; if ({s_vwe, s_vaddr, s_vwd} !== {1'b1, 14'h2108, 8'hAA}) $display("FAIL vram_we: got %b %h %h exp 1 2108 aa", s_vwe, s_vaddr, s_vwd); else n_pass++;
    n_tot++; if (s_strobe2 !== 1'b0) $display("FAIL vram_we_width: got %b exp 0", s_strobe2); else n_pass++;
    n_tot++; if (v_addr !== 15'h2109) $display("FAIL v_inc1: got %h exp 2109", v_addr); else n_pass++;
    drive(1, 0, 0, 'h04, 0, 0);
    drive(1, 0, 7, 'h33, 0, 0);
    n_tot++; if (v_addr !== 15'h2129) $display("FAIL v_inc32: got %h exp 2129", v_addr); else n_pass++;
  endtask

  task automatic test_vram_read();
    drive(1, 0, 0, 'h00, 0, 0);
    drive(1, 0, 6, 'h24, 0, 0); drive(1, 0, 6, 'h00, 0, 0);
    drive(1, 0, 7, 'h55, 0, 0);
    drive(1, 0, 6, 'h24, 0, 0); drive(1, 0, 6, 'h00, 0, 0);
    drive(1, 1, 7, 0, 0, 0);
    n_tot++; if (s_rdata !== m_rdata) $display("FAIL data_rd_old_buf: got %h exp %h", s_rdata, m_rdata); else n_pass++;
    n_tot++; if ({s_vre, s_vaddr} !== {1'b1, 14'h2400}) $display("FAIL vram_re: got %b %h exp 1 2400", s_vre, s_vaddr); else n_pass++;
    drive(1, 1, 7, 0, 0, 0);
    n_tot++; if (s_rdata !== 8'h55) $display("FAIL data_rd_buf: got %h exp 55", s_rdata); else n_pass++;
    n_tot++; if (v_addr !== 15'h2402) $display("FAIL v_after_rd: got %h exp 2402", v_addr); else n_pass++;
  endtask

  task automatic test_nmi();
    drive(1, 0, 0, 'h80, 0, 0);
    n_tot++; if (s_nmi !== 1'b0) $display("FAIL nmi_no_vbl: got %b exp 0", s_nmi); else n_pass++;
    drive(0, 0, 0, 0, 1, 0);
    n_tot++; if (s_nmi !== 1'b1) $display("FAIL nmi_on_vbl: got %b exp 1", s_nmi); else n_pass++;
    drive(1, 1, 2, 0, 0, 0);
    n_tot++; if (s_rdata[7] !== 1'b1 || s_nmi !== 1'b0) $display("FAIL status_rd1: got bit7=%b nmi=%b exp 1 0", s_rdata[7], s_nmi); else n_pass++;
    drive(1, 1, 2, 0, 0, 0);
    n_tot++; if (s_rdata[7] !== 1'b0) $display("FAIL status_rd2: got %b exp 0", s_rdata[7]); else n_pass++;
    drive(1, 0, 0, 'h00, 0, 0);
    drive(0, 0, 0, 0, 1, 0);
    drive(1, 0, 0, 'h80, 0, 0);
    n_tot++; if (s_nmi !== 1'b1) $display("FAIL nmi_late_enable: got %b exp 1", s_nmi); else n_pass++;
    drive(1, 0, 0, 'h00, 0, 0);
    n_tot++; if (s_nmi !== 1'b0) $display("FAIL nmi_disable: got %b exp 0", s_nmi); else n_pass++;
    drive(0, 0, 0, 0, 8, 0);
  endtask

  task automatic test_race();
    drive(1, 0, 0, 'h80, 0, 0);
    drive(1, 1, 2, 0, 1, 0);
    n_tot++; if (s_rdata[7] !== 1'b0 || s_nmi !== 1'b0) $display("FAIL race_rd: got bit7=%b nmi=%b exp 0 0", s_rdata[7], s_nmi); else n_pass++;
    n_tot++; if (nmi !== 1'b0) $display("FAIL race_nmi_later: got %b exp 0", nmi); else n_pass++;
    drive(1, 1, 2, 0, 0, 0);
    n_tot++; if (s_rdata[7] !== 1'b0) $display("FAIL race_vbl_stays0: got %b exp 0", s_rdata[7]); else n_pass++;
  endtask

  task automatic test_flags();
    drive(0, 0, 0, 0, 2 | 8, 0);
    drive(1, 1, 2, 0, 0, 0);
    n_tot++; if (s_rdata[6] !== 1'b0) $display("FAIL spr0_clr_wins: got %b exp 0", s_rdata[6]); else n_pass++;
    drive(0, 0, 0, 0, 2, 0);
    drive(0, 0, 0, 0, 4, 0);
    drive(1, 1, 2, 0, 0, 0);
    n_tot++; if (s_rdata[6:5] !== 2'b11) $display("FAIL spr_flags_set: got %b exp 11", s_rdata[6:5]); else n_pass++;
    drive(0, 0, 0, 0, 8, 0);
    drive(1, 1, 2, 0, 0, 0);
    n_tot++; if (s_rdata[7:5] !== 3'b000) $display("FAIL flags_cleared: got %b exp 000", s_rdata[7:5]); else n_pass++;
  endtask

  task automatic test_oam();
    drive(1, 0, 3, 'hFF, 0, 0);
    drive(1, 0, 4, 'h11, 0, 0);
    n_tot++; if ({s_owe, s_oaddr, s_owd} !== {1'b1, 8'hFF, 8'h11}) $display("FAIL oam_we: got %b %h %h exp 1 ff 11", s_owe, s_oaddr, s_owd); else n_pass++;
    n_tot++; if (s_strobe2 !== 1'b0 || oam_addr !== 8'h00) $display("FAIL oam_wrap: got we2=%b addr=%h exp 0 00", s_strobe2, oam_addr); else n_pass++;
    drive(1, 1, 4, 0, 0, 0);
    n_tot++; if (s_rdata !== 8'h5A || oam_addr !== 8'h00) $display("FAIL oam_rd: got %h addr=%h exp 5a 00", s_rdata, oam_addr); else n_pass++;
  endtask

  task automatic test_scroll();
    drive(1, 0, 0, 'h00, 0, 0);
    drive(1, 1, 2, 0, 0, 0);
    drive(1, 0, 5, 'h7D, 0, 0);
    drive(1, 0, 5, 'h5E, 0, 0);
    n_tot++; if (t_addr !== 15'h616F || fine_x !== 3'd5) $display("FAIL scroll: got t=%h fx=%0d exp 616f 5", t_addr, fine_x); else n_pass++;
    drive(1, 0, 6, 'h3F, 0, 0);
    n_tot++; if (t_addr !== 15'(m_t) || v_addr !== 15'(m_v)) $display("FAIL toggle_cleared: got t=%h v=%h exp %h %h", t_addr, v_addr, 15'(m_t), 15'(m_v)); else n_pass++;
  endtask

  task automatic test_vext();
    drive(0, 0, 0, 0, 16, 'h7FFF);
    n_tot++; if (v_addr !== 15'h7FFF) $display("FAIL vext_load: got %h exp 7fff", v_addr); else n_pass++;
    drive(1, 0, 7, 'h3C, 0, 0);
    n_tot++; if (s_vaddr !== 14'h3FFF || v_addr !== 15'h0000) $display("FAIL v_wrap: got %h %h exp 3fff 0000", s_vaddr, v_addr); else n_pass++;
    drive(1, 1, 2, 0, 0, 0);
    drive(1, 0, 6, 'h11, 0, 0);
    drive(1, 0, 6, 'h22, 16, 'h1234);
    n_tot++; if (v_addr !== 15'h1234 || t_addr !== 15'h1122) $display("FAIL vext_priority: got v=%h t=%h exp 1234 1122", v_addr, t_addr); else n_pass++;
  endtask

  task automatic test_random();
    int a, d, side, vx;
    bit r;
    for (int i = 0; i < 300; i++) begin
      a    = int'($urandom % 8);
      r    = 1'($urandom % 2);
      d    = int'($urandom % 256);
      side = (($urandom % 4) == 0) ? int'($urandom % 32) : 0;
      vx   = int'($urandom % 32768);
      drive(1, r, a, d, side, vx);
      n_tot++; if (s_rdata !== m_rdata) $display("FAIL rnd_rdata[%0d]: got %h exp %h", i, s_rdata, m_rdata); else n_pass++;
      n_tot++; if (s_nmi !== m_nmi()) $display("FAIL rnd_nmi[%0d]: got %b exp %b", i, s_nmi, m_nmi()); else n_pass++;
      n_tot++; if ({t_addr, v_addr, fine_x} !== {15'(m_t), 15'(m_v), 3'(m_fx)}) $display("FAIL rnd_tvx[%0d]: got %h %h %0d exp %h %h %0d", i, t_addr, v_addr, fine_x, 15'(m_t), 15'(m_v), m_fx); else n_pass++;
      n_tot++; if ({ctrl_q, mask_q, oam_addr} !== {8'(m_ctrl), 8'(m_mask), 8'(m_oam)}) $display("FAIL rnd_regs[%0d]: got %h %h %h exp %h %h %h", i, ctrl_q, mask_q, oam_addr, 8'(m_ctrl), 8'(m_mask), 8'(m_oam)); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_vram_write();
    test_vram_read();
    test_nmi();
    test_race();
    test_flags();
    test_oam();
    test_scroll();
    test_vext();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
